// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter in front of the SPART packing wrapper: latches the winning
// requester's packet, strobes send_tx once, then blocks further sends for GAP_CYCLES.
module spart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 15000,
  parameter int DATA_W     = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      send_tx,
  output logic [DATA_W-1:0]         tx_data
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [OWN_W-1:0] LAST_RST    = OWN_W'(NUM_REQ - 1);
  localparam logic [OWN_W:0]   NUM_REQ_EXT = (OWN_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [OWN_W-1:0]    r_owner;
  logic [OWN_W-1:0]    r_last_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_send_tx;
  logic                r_busy;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;

  logic                w_found;
  logic [OWN_W-1:0]    w_winner;
  logic [OWN_W:0]      w_sum;
  logic [OWN_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_win_data;

  state_t              w_state_nxt;
  logic [OWN_W-1:0]    w_owner_nxt;
  logic [OWN_W-1:0]    w_last_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_tx_nxt;
  logic                w_send_nxt;
  logic                w_busy_nxt;
  logic                w_done_fire;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;

  // Round-robin pick: first pending request scanning upward from last_owner+1, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_owner;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last_owner} + (OWN_W + 1)'(k);
      w_sum = (w_sum >= NUM_REQ_EXT) ? (w_sum - NUM_REQ_EXT) : w_sum;
      w_idx = w_sum[OWN_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Packet mux for the current winner.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_data = (w_winner == OWN_W'(i)) ? req_data[i*DATA_W +: DATA_W] : w_win_data;
    end
  end

  // Next-state and datapath updates for IDLE -> SEND -> WAIT -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_cnt;
    w_tx_nxt    = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_SEND;
          w_owner_nxt = w_winner;
          w_tx_nxt    = w_win_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        w_last_nxt  = r_owner;
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    w_send_nxt  = (w_state_nxt == S_SEND);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_fire = (w_state_nxt == S_WAIT) && (w_cnt_nxt == '0);
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_nxt[i]  = w_send_nxt  && (w_owner_nxt == OWN_W'(i));
      w_done_nxt[i] = w_done_fire && (w_owner_nxt == OWN_W'(i));
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= LAST_RST;
      r_cnt        <= '0;
      r_tx_data    <= '0;
      r_send_tx    <= 1'b0;
      r_busy       <= 1'b0;
      r_gnt        <= '0;
      r_done       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_data    <= w_tx_nxt;
      r_send_tx    <= w_send_nxt;
      r_busy       <= w_busy_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign busy    = r_busy;
  assign send_tx = r_send_tx;
  assign tx_data = r_tx_data;

endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Directed bench for spart_tx_arbiter with NUM_REQ=2, GAP_CYCLES=8.
// Cycle c is the interval starting 1 time unit after the c-th rising edge following stimulus.
module tb_spart_tx_arbiter;

  localparam int NR  = 2;
  localparam int GAP = 8;
  localparam int DW  = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             busy;
  logic             send_tx;
  logic [DW-1:0]    tx_data;

  int total = 0;
  int bad   = 0;

  spart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .send_tx(send_tx), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    step();
    total++; if (send_tx !== 1'b0) begin bad++; $display("FAIL reset send_tx got=%b exp=0", send_tx); end
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset gnt got=%b exp=00", gnt); end
    total++; if (done !== 2'b00) begin bad++; $display("FAIL reset done got=%b exp=00", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (tx_data !== 24'h000000) begin bad++; $display("FAIL reset tx_data got=%h exp=000000", tx_data); end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++; if ({busy, send_tx} !== 2'b00) begin bad++; $display("FAIL idle_noreq c=%0d busy/send got=%b exp=00", c, {busy, send_tx}); end
    end
  endtask

  task automatic test_single();
    logic          es, eb;
    logic [NR-1:0] eg, ed;
    do_reset();
    req_data[0 +: DW] = 24'hA1B2C3;
    req = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      step();
      es = (c == 1);
      eg = (c == 1) ? 2'b01 : 2'b00;
      ed = (c == 9) ? 2'b01 : 2'b00;
      eb = (c >= 1) && (c <= 9);
      total++; if (send_tx !== es) begin bad++; $display("FAIL single send_tx c=%0d got=%b exp=%b", c, send_tx, es); end
      total++; if (gnt !== eg) begin bad++; $display("FAIL single gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      total++; if (done !== ed) begin bad++; $display("FAIL single done c=%0d got=%b exp=%b", c, done, ed); end
      total++; if (busy !== eb) begin bad++; $display("FAIL single busy c=%0d got=%b exp=%b", c, busy, eb); end
      total++; if (tx_data !== 24'hA1B2C3) begin bad++; $display("FAIL single tx_data c=%0d got=%h exp=a1b2c3", c, tx_data); end
      if (c == 1) req = 2'b00;
    end
  endtask

  task automatic test_two_simul();
    logic          es;
    logic [NR-1:0] eg, ed;
    logic [DW-1:0] et;
    do_reset();
    req_data[0 +: DW]  = 24'h111111;
    req_data[DW +: DW] = 24'h222222;
    req = 2'b11;
    for (int c = 1; c <= 22; c++) begin
      step();
      es = (c == 1) || (c == 11);
      eg = (c == 1) ? 2'b01 : ((c == 11) ? 2'b10 : 2'b00);
      ed = (c == 9) ? 2'b01 : ((c == 19) ? 2'b10 : 2'b00);
      et = (c < 11) ? 24'h111111 : 24'h222222;
      total++; if (send_tx !== es) begin bad++; $display("FAIL two send_tx c=%0d got=%b exp=%b", c, send_tx, es); end
      total++; if (gnt !== eg) begin bad++; $display("FAIL two gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      total++; if (done !== ed) begin bad++; $display("FAIL two done c=%0d got=%b exp=%b", c, done, ed); end
      total++; if (tx_data !== et) begin bad++; $display("FAIL two tx_data c=%0d got=%h exp=%h", c, tx_data, et); end
      if (c == 1)  req[0] = 1'b0;
      if (c == 11) req[1] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic          es;
    logic [NR-1:0] eg;
    do_reset();
    req_data[0 +: DW]  = 24'h111111;
    req_data[DW +: DW] = 24'h222222;
    req = 2'b11;
    for (int c = 1; c <= 45; c++) begin
      step();
      es = ((c - 1) % 10 == 0);
      eg = es ? ((((c - 1) / 10) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      total++; if (send_tx !== es) begin bad++; $display("FAIL b2b send_tx c=%0d got=%b exp=%b", c, send_tx, es); end
      total++; if (gnt !== eg) begin bad++; $display("FAIL b2b gnt c=%0d got=%b exp=%b", c, gnt, eg); end
    end
    req = 2'b00;
  endtask

  task automatic test_midwait_req();
    logic          es;
    logic [NR-1:0] eg, ed;
    logic [DW-1:0] et;
    do_reset();
    req_data[0 +: DW] = 24'h010203;
    req = 2'b01;
    for (int c = 1; c <= 21; c++) begin
      step();
      es = (c == 1) || (c == 11);
      eg = (c == 1) ? 2'b01 : ((c == 11) ? 2'b10 : 2'b00);
      ed = (c == 9) ? 2'b01 : ((c == 19) ? 2'b10 : 2'b00);
      et = (c < 11) ? 24'h010203 : 24'h333333;
      total++; if (send_tx !== es) begin bad++; $display("FAIL midwait send_tx c=%0d got=%b exp=%b", c, send_tx, es); end
      total++; if (gnt !== eg) begin bad++; $display("FAIL midwait gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      total++; if (done !== ed) begin bad++; $display("FAIL midwait done c=%0d got=%b exp=%b", c, done, ed); end
      total++; if (tx_data !== et) begin bad++; $display("FAIL midwait tx_data c=%0d got=%h exp=%h", c, tx_data, et); end
      if (c == 1) req[0] = 1'b0;
      if (c == 4) begin
        req_data[DW +: DW] = 24'h333333;
        req[1] = 1'b1;
      end
      if (c == 11) req[1] = 1'b0;
    end
  endtask

  task automatic test_reset_midwait();
    logic [NR-1:0] ed;
    do_reset();
    req_data[0 +: DW] = 24'h444444;
    req = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req = 2'b00;
    end
    // cycle 6: WAIT with counter at 3
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstwait pre_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({send_tx, busy} !== 2'b00) begin bad++; $display("FAIL rstwait async send/busy got=%b exp=00", {send_tx, busy}); end
    total++; if ({gnt, done} !== 4'b0000) begin bad++; $display("FAIL rstwait async gnt/done got=%b exp=0000", {gnt, done}); end
    total++; if (tx_data !== 24'h000000) begin bad++; $display("FAIL rstwait async tx_data got=%h exp=000000", tx_data); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if ({done, busy} !== 3'b000) begin bad++; $display("FAIL rstwait hold done/busy got=%b exp=000", {done, busy}); end
    end
    rst_n = 1'b1;
    req_data[DW +: DW] = 24'h555555;
    req = 2'b10;
    for (int c = 1; c <= 10; c++) begin
      step();
      ed = (c == 9) ? 2'b10 : 2'b00;
      if (c == 1) begin
        total++; if (send_tx !== 1'b1) begin bad++; $display("FAIL rstwait regrant send_tx got=%b exp=1", send_tx); end
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rstwait regrant gnt got=%b exp=10", gnt); end
        req = 2'b00;
      end
      total++; if (tx_data !== 24'h555555) begin bad++; $display("FAIL rstwait tx_data c=%0d got=%h exp=555555", c, tx_data); end
      total++; if (done !== ed) begin bad++; $display("FAIL rstwait done c=%0d got=%b exp=%b", c, done, ed); end
    end
  endtask

  task automatic test_rr_after_reset();
    do_reset();
    req_data[0 +: DW]  = 24'h0000AA;
    req_data[DW +: DW] = 24'h0000BB;
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    step();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 2'b11;
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rr_after_reset gnt got=%b exp=01", gnt); end
    total++; if (tx_data !== 24'h0000AA) begin bad++; $display("FAIL rr_after_reset tx_data got=%h exp=0000aa", tx_data); end
    req = 2'b00;
  endtask

  task automatic test_data_hold();
    logic [NR-1:0] ed;
    do_reset();
    req_data[0 +: DW] = 24'h0ABCDE;
    req = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      step();
      ed = (c == 9) ? 2'b01 : 2'b00;
      total++; if (tx_data !== 24'h0ABCDE) begin bad++; $display("FAIL hold tx_data c=%0d got=%h exp=0abcde", c, tx_data); end
      total++; if (done !== ed) begin bad++; $display("FAIL hold done c=%0d got=%b exp=%b", c, done, ed); end
      if (c == 1) begin
        req = 2'b00;
        req_data[0 +: DW] = 24'hFFFFFF;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_two_simul();
    test_back_to_back();
    test_midwait_req();
    test_reset_midwait();
    test_rr_after_reset();
    test_data_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
